// File: rtl/ahb_si_arbiter_pkg.sv
// Shared AHB encodings and arbiter state for the per-slave arbiter.
package ahb_si_arbiter_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HB_SINGLE = 3'd0,
        HB_INCR   = 3'd1,
        HB_WRAP4  = 3'd2,
        HB_INCR4  = 3'd3,
        HB_WRAP8  = 3'd4,
        HB_INCR8  = 3'd5,
        HB_WRAP16 = 3'd6,
        HB_INCR16 = 3'd7
    } hburst_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OWN,
        ST_BURST,
        ST_BURST_U
    } arb_state_t;

    localparam int BEATS_W = 4;

    // Remaining beats after the NONSEQ of a fixed-length burst.
    function automatic logic [BEATS_W-1:0] burst_beats_m1(hburst_t hb);
        case (hb)
            HB_WRAP4,  HB_INCR4:  burst_beats_m1 = 4'd3;
            HB_WRAP8,  HB_INCR8:  burst_beats_m1 = 4'd7;
            HB_WRAP16, HB_INCR16: burst_beats_m1 = 4'd15;
            default:              burst_beats_m1 = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_si_arbiter_picker.sv
// Round-robin picker: first requester searching upward from rr_ptr, wrapping.
module ahb_rr_picker #(
    parameter int CHANNEL_NUM = 3,
    parameter int PTR_W       = 2
) (
    input  logic [CHANNEL_NUM-1:0] req,
    input  logic [PTR_W-1:0]       rr_ptr,
    output logic [CHANNEL_NUM-1:0] pick,
    output logic                   valid
);

    int idx;

    always_comb begin
        pick  = '0;
        valid = 1'b0;
        idx   = 0;
        for (int k = 0; k < CHANNEL_NUM; k++) begin
            idx = (int'(rr_ptr) + k) % CHANNEL_NUM;
            if (!valid && req[idx]) begin
                pick[idx] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_si_arbiter.sv
// Per-slave AHB arbiter: burst-holding round-robin grant with HREADY-timed
// handover and a one-transfer-delayed data-phase select.
module ahb_si_arbiter
    import ahb_si_arbiter_pkg::*;
#(
    parameter int CHANNEL_NUM = 3,
    parameter int CNT_W       = 4
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic [CHANNEL_NUM-1:0]   req,
    input  logic [2*CHANNEL_NUM-1:0] htrans,
    input  logic [3*CHANNEL_NUM-1:0] hburst,
    input  logic                     hready,
    output logic [CHANNEL_NUM-1:0]   sel,
    output logic [CHANNEL_NUM-1:0]   sel_data,
    output logic                     busy
);

    localparam int PTR_W = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;

    arb_state_t             state, state_nxt;
    logic [CHANNEL_NUM-1:0] sel_nxt, pick;
    logic [PTR_W-1:0]       rr_ptr, rr_nxt;
    logic [CNT_W-1:0]       beat_cnt, cnt_nxt;
    logic                   pick_vld, rel;
    int                     own_i, pick_i;
    htrans_t                own_ht;
    hburst_t                own_hb;

    ahb_rr_picker #(.CHANNEL_NUM(CHANNEL_NUM), .PTR_W(PTR_W)) u_pick (
        .req   (req),
        .rr_ptr(rr_ptr),
        .pick  (pick),
        .valid (pick_vld)
    );

    always_comb begin
        own_i  = 0;
        pick_i = 0;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            if (sel[i])  own_i  = i;
            if (pick[i]) pick_i = i;
        end
        own_ht = htrans_t'(htrans[2*own_i +: 2]);
        own_hb = hburst_t'(hburst[3*own_i +: 3]);
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        rr_nxt    = rr_ptr;
        cnt_nxt   = beat_cnt;
        rel       = 1'b0;
        // A stalled slave freezes everything, including an unowned port.
        if (hready) begin
            case (state)
                ST_IDLE: rel = 1'b1;
                ST_OWN: begin
                    if (!req[own_i]) begin
                        rel = 1'b1;
                    end else if (own_ht == HT_NONSEQ) begin
                        case (own_hb)
                            HB_SINGLE: rel = 1'b1;
                            HB_INCR:   state_nxt = ST_BURST_U;
                            default: begin
                                state_nxt = ST_BURST;
                                cnt_nxt   = CNT_W'(burst_beats_m1(own_hb));
                            end
                        endcase
                    end else if (own_ht == HT_IDLE) begin
                        rel = 1'b1;
                    end
                end
                ST_BURST: begin
                    case (own_ht)
                        HT_SEQ: begin
                            if (beat_cnt == CNT_W'(1)) rel = 1'b1;
                            else cnt_nxt = beat_cnt - CNT_W'(1);
                        end
                        HT_BUSY: ;
                        default: rel = 1'b1;
                    endcase
                end
                ST_BURST_U: begin
                    if (own_ht == HT_IDLE || own_ht == HT_NONSEQ) rel = 1'b1;
                end
                default: rel = 1'b1;
            endcase
        end
        if (rel) begin
            cnt_nxt = '0;
            if (pick_vld) begin
                state_nxt = ST_OWN;
                sel_nxt   = pick;
                rr_nxt    = PTR_W'((pick_i + 1) % CHANNEL_NUM);
            end else begin
                state_nxt = ST_IDLE;
                sel_nxt   = '0;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= ST_IDLE;
            sel      <= '0;
            sel_data <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            sel      <= sel_nxt;
            rr_ptr   <= rr_nxt;
            beat_cnt <= cnt_nxt;
            busy     <= (state_nxt != ST_IDLE);
            if (hready) sel_data <= sel;
        end
    end

endmodule

// File: doc/ahb_si_arbiter.md
Name: ahb_si_arbiter

Overview:
Per-slave arbiter for the AHB interconnect's slave interface. It chooses one of CHANNEL_NUM masters to own the slave port and drives the one-hot `sel` of the master-payload mux (address phase). It also drives a delayed one-hot `sel_data` for the data-phase return path. Ownership is held for the whole burst, and handover is timed on HREADY so there is no idle bubble between owners.

Parameters:
- CHANNEL_NUM, 3, number of competing masters; must be at least 2.
- CNT_W, 4, beat-counter width; covers 16-beat bursts.

Ports:
- HCLK, in, 1, system clock.
- HRESETn, in, 1, asynchronous active-low reset.
- req, in, CHANNEL_NUM, per-master request from the address decoder (master addresses this slave with HTRANS != IDLE).
- htrans, in, CHANNEL_NUM x 2, per-master HTRANS.
- hburst, in, CHANNEL_NUM x 3, per-master HBURST.
- hready, in, 1, HREADY returned by the slave.
- sel, out, CHANNEL_NUM, one-hot address-phase grant; all zeros means no owner.
- sel_data, out, CHANNEL_NUM, one-hot data-phase owner.
- busy, out, 1, high while the state is not IDLE.

Behaviour:
- Reset (async, HRESETn=0):
  - state=IDLE; sel=0; sel_data=0; busy=0.
  - rr_ptr=0 (channel 0 has top priority first); beat_cnt=0.
- Round-robin pick: the first requester searching upward from rr_ptr, modulo CHANNEL_NUM. When a grant is issued, rr_ptr becomes (granted index + 1) mod CHANNEL_NUM.
- All outputs are registered. A request at cycle t gives sel at t+1.
- States:
  - IDLE: sel=0.
    - If any req is high: register the pick into sel and go to OWN.
  - OWN: owner o = index of sel.
    - On hready=1 with htrans[o]=NONSEQ:
      - SINGLE: release.
      - INCR4 or WRAP4: beat_cnt=3, go to BURST.
      - INCR8 or WRAP8: beat_cnt=7, go to BURST.
      - INCR16 or WRAP16: beat_cnt=15, go to BURST.
      - INCR: go to BURST_U.
    - On hready=1 with htrans[o]=IDLE: release.
    - hready=0: hold everything.
  - BURST: fixed-length burst.
    - On hready=1 with htrans[o]=SEQ: beat_cnt decrements.
    - The beat accepted while beat_cnt=1 is the last; release on it.
    - BUSY: hold, no decrement.
    - IDLE or NONSEQ (early termination): release. A NONSEQ is treated as a new arbitration candidate.
  - BURST_U: undefined-length INCR.
    - Hold while htrans[o] is SEQ or BUSY.
    - Release on hready=1 with htrans[o] IDLE or NONSEQ.
- Release, on the same HCLK edge that accepts the final address beat:
  - If any req is high, sel gets the round-robin pick and the state goes to OWN. The old owner is eligible only per round-robin order; it regains the grant if it is the sole requester.
  - Otherwise sel=0 and the state goes to IDLE.
  - The new owner's address phase begins the next cycle, with no bubble.
- sel_data: loads sel on every edge with hready=1 and holds when hready=0. It therefore lags sel by one accepted transfer.
- If the owner's req drops while in OWN before any NONSEQ is accepted: release on the next edge.
- hready=0 freezes sel, state, beat_cnt and sel_data regardless of req changes.
- Invariant: sel and sel_data are always one-hot or zero. The verifier asserts this.
- Async reset mid-burst: everything returns to reset values immediately. There is no recovery of the partial burst.

Decomposition:
- AHB_package holds:
  - htrans_t: IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11.
  - hburst_t: SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7.
  - arb_state_t: IDLE, OWN, BURST, BURST_U.
  - A function mapping hburst to beats-1.
- One sub-module: ahb_rr_picker. Combinational; inputs req and rr_ptr; outputs a one-hot pick and a valid flag.

Test Plan:
- Reset, then req=3'b010 at cycle 2 -> sel=3'b010 at cycle 3, busy=1. SINGLE NONSEQ with hready=1 -> sel=0 next cycle, state IDLE.
- Masters 0 and 2 both request and keep issuing SINGLE transfers -> sel alternates 001, 100, 001, ... one grant per accepted transfer.
- Master 1 INCR4: NONSEQ, then 3 SEQ with one BUSY inserted, while master 0 requests -> sel stays 010 for all 4 beats plus the BUSY cycle. sel becomes 001 on the edge that accepts beat 4.
- hready held 0 for 3 cycles mid-INCR8 -> sel, sel_data and beat_cnt are frozen. After hready returns, 8 beats in total are accepted before release.
- Master 2 INCR (undefined) for 6 SEQ beats, then IDLE -> release on the IDLE edge. sel_data=100 for the 6 data phases, lagging sel by one accepted transfer.
- HRESETn pulsed low mid-WRAP16 at beat 5 -> sel=0, sel_data=0 and busy=0 immediately. After reset releases, channel 0 wins the first tie among all three requesters.
